me_sad_search_engine: RTL

Parametrised full-search block-matching motion estimator. Computes the sum of absolute differences (SAD) between a BLK×BLK reference block and every candidate position in a search window. Reports the best motion vector and its full-width distance. Sits behind the reference and search pixel memories of the motion-estimation datapath and supersedes the fixed 16×16 / 8-bit-distance estimator. Adds generic block and range sizes, lossless distance width, a defined tie-break rule and an optional early-termination mode.

---
 rtl/me_sad_search_engine_if.sv | 36 +++
 rtl/me_sad_search_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/me_sad_search_engine_if.sv
// Handshake, memory-read and result bundle of the SAD search engine.
// master: requester side (start, pixel data); slave: engine side.
interface me_sad_search_engine_if #(
  parameter int PIXEL_W = 8,
  parameter int BLK     = 16,
  parameter int SRCH    = 16
);
  localparam int W      = BLK + SRCH - 1;
  localparam int RA_W   = $clog2(BLK * BLK);
  localparam int SA_W   = $clog2(W * W);
  localparam int MV_W   = (SRCH > 1) ? $clog2(SRCH) : 1;
  localparam int DIST_W = PIXEL_W + $clog2(BLK * BLK);

  logic               start;
  logic               busy;
  logic               done;
  logic [RA_W-1:0]    addr_r;
  logic [SA_W-1:0]    addr_s;
  logic [PIXEL_W-1:0] r_data;
  logic [PIXEL_W-1:0] s_data;
  logic [MV_W-1:0]    motion_x;
  logic [MV_W-1:0]    motion_y;
  logic [DIST_W-1:0]  best_sad;

  modport master (
    output start, r_data, s_data,
    input  busy, done, addr_r, addr_s,
    input  motion_x, motion_y, best_sad
  );

  modport slave (
    input  start, r_data, s_data,
    output busy, done, addr_r, addr_s,
    output motion_x, motion_y, best_sad
  );
endinterface

// File: rtl/me_sad_search_engine.sv
// Full-search block-matching SAD motion estimator.
// Ports: clk, reset (async, high); bus = slave modport of
// me_sad_search_engine_if (start/busy/done, addr_r/addr_s,
// r_data/s_data, motion_x/motion_y/best_sad).
// Optional macro ME_EARLY_TERM_EN: abort a candidate once its
// partial SAD can no longer beat the best one.
module me_sad_search_engine #(
  parameter int PIXEL_W = 8,
  parameter int BLK     = 16,
  parameter int SRCH    = 16
) (
  input  logic clk,
  input  logic reset,
  me_sad_search_engine_if.slave bus
);
  localparam int W      = BLK + SRCH - 1;
  localparam int RA_W   = $clog2(BLK * BLK);
  localparam int SA_W   = $clog2(W * W);
  localparam int MV_W   = (SRCH > 1) ? $clog2(SRCH) : 1;
  localparam int DIST_W = PIXEL_W + $clog2(BLK * BLK);
  localparam int IX_W   = (BLK > 1) ? $clog2(BLK) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_CMP, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [IX_W-1:0]   r_i, r_j;
  logic [MV_W-1:0]   r_mx, r_my;
  logic [MV_W-1:0]   r_bmx, r_bmy;
  logic [MV_W-1:0]   r_mv_x, r_mv_y;
  logic [DIST_W-1:0] r_acc, r_best, r_sad;
  logic              r_best_vld;
  logic              r_rd_vld;
  logic              r_done;

  logic              w_last_pix;
  logic              w_last_cand;
  logic              w_better;
  logic              w_abort;
  logic [PIXEL_W:0]  w_abs;

  assign w_last_pix  = (r_i == IX_W'(BLK - 1)) &&
                       (r_j == IX_W'(BLK - 1));
  assign w_last_cand = (r_mx == MV_W'(SRCH - 1)) &&
                       (r_my == MV_W'(SRCH - 1));
  assign w_better    = !r_best_vld || (r_acc < r_best);

  assign w_abs = (bus.r_data >= bus.s_data)
    ? ({1'b0, bus.r_data} - {1'b0, bus.s_data})
    : ({1'b0, bus.s_data} - {1'b0, bus.r_data});

`ifdef ME_EARLY_TERM_EN
  // Partial SAD already ties or exceeds best: strict compare
  // can never select this candidate, so stop reading it.
  assign w_abort = r_best_vld && (r_acc >= r_best);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN: begin
        if (w_abort)         w_next = S_CMP;
        else if (w_last_pix) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_CMP;
      S_CMP:   w_next = w_last_cand ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i        <= '0;
      r_j        <= '0;
      r_mx       <= '0;
      r_my       <= '0;
      r_bmx      <= '0;
      r_bmy      <= '0;
      r_mv_x     <= '0;
      r_mv_y     <= '0;
      r_acc      <= '0;
      r_best     <= '0;
      r_sad      <= '0;
      r_best_vld <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Read data returns one cycle after a RUN address.
      r_rd_vld <= (r_state == S_RUN);
      r_done   <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          r_i        <= '0;
          r_j        <= '0;
          r_mx       <= '0;
          r_my       <= '0;
          r_acc      <= '0;
          r_best_vld <= 1'b0;
        end
        S_RUN: begin
          if (r_rd_vld) r_acc <= r_acc + DIST_W'(w_abs);
          if (r_i == IX_W'(BLK - 1)) begin
            r_i <= '0;
            r_j <= r_j + IX_W'(1);
          end else begin
            r_i <= r_i + IX_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_rd_vld) r_acc <= r_acc + DIST_W'(w_abs);
        end
        S_CMP: begin
          if (w_better) begin
            r_best     <= r_acc;
            r_best_vld <= 1'b1;
            r_bmx      <= r_mx;
            r_bmy      <= r_my;
          end
          r_acc <= '0;
          r_i   <= '0;
          r_j   <= '0;
          if (r_mx == MV_W'(SRCH - 1)) begin
            r_mx <= '0;
            r_my <= r_my + MV_W'(1);
          end else begin
            r_mx <= r_mx + MV_W'(1);
          end
        end
        S_DONE: begin
          r_sad  <= r_best;
          r_mv_x <= r_bmx;
          r_mv_y <= r_bmy;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.motion_x = r_mv_x;
  assign bus.motion_y = r_mv_y;
  assign bus.best_sad = r_sad;

  assign bus.addr_r = (r_state == S_RUN)
    ? RA_W'(32'(r_j) * BLK + 32'(r_i)) : '0;
  assign bus.addr_s = (r_state == S_RUN)
    ? SA_W'((32'(r_my) + 32'(r_j)) * W
            + 32'(r_mx) + 32'(r_i)) : '0;
endmodule
